// File: rtl/prbs31_pam4_symbol_checker_pkg.sv
// -----------------------------------------------------------------------------
// prbs31_pam4_symbol_checker_pkg
//
// Shared definitions for the PAM-4 PRBS31 symbol checker:
//   - PRBS31 (x^31 + x^28 + 1) register length and feedback tap indices
//   - Gray-to-binary decode of a 2-bit PAM-4 symbol
//   - Lock supervisor state encoding
// -----------------------------------------------------------------------------
package prbs31_pam4_symbol_checker_pkg;

    // Length of the PRBS31 shift register.
    localparam int PRBS_LEN = 31;

    // Feedback taps: the next bit is s[TAP_A] ^ s[TAP_B], shifted in at s[0].
    localparam int TAP_A = 30;
    localparam int TAP_B = 27;

    // Lock supervisor states.
    typedef enum logic {
        ST_SEED   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Gray decode of one PAM-4 symbol: {b1, b0} = {g1, g1 ^ g0}.
    // b1 is the earlier bit of the PRBS stream.
    function automatic logic [1:0] gray_decode(input logic [1:0] gray);
        return {gray[1], gray[1] ^ gray[0]};
    endfunction

endpackage

// File: rtl/prbs31_pam4_symbol_checker_lfsr.sv
// -----------------------------------------------------------------------------
// prbs31_lfsr_2step
//
// PRBS31 shift register that moves two bits per symbol. It either loads the two
// received bits (seeding) or advances with its own two predicted bits
// (checking), so a received bit error never corrupts the local sequence.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset (register cleared to 0)
//   load_en_i     in   shift rx_bits_i into the register this cycle
//   advance_en_i  in   shift the predicted bits into the register this cycle
//   rx_bits_i     in   received binary bits {b1, b0}, b1 earlier
//   pred_bits_o   out  predicted bits {p1, p0} for the current symbol
//   load_zero_o   out  register would be all-zero after loading rx_bits_i
// -----------------------------------------------------------------------------
module prbs31_lfsr_2step
    import prbs31_pam4_symbol_checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en_i,
    input  logic       advance_en_i,
    input  logic [1:0] rx_bits_i,
    output logic [1:0] pred_bits_o,
    output logic       load_zero_o
);

    logic [PRBS_LEN-1:0] state_q;
    logic [PRBS_LEN-1:0] state_d;
    logic [PRBS_LEN-1:0] load_val;
    logic                p1;
    logic                p0;

    // p0 is the second step of the recurrence; its taps sit one position
    // lower because p1 has conceptually been shifted in already.
    assign p1 = state_q[TAP_A] ^ state_q[TAP_B];
    assign p0 = state_q[TAP_A-1] ^ state_q[TAP_B-1];
    assign pred_bits_o = {p1, p0};

    assign load_val    = {state_q[PRBS_LEN-3:0], rx_bits_i};
    assign load_zero_o = (load_val == '0);

    always_comb begin
        state_d = state_q;
        if (load_en_i) begin
            state_d = load_val;
        end else if (advance_en_i) begin
            state_d = {state_q[PRBS_LEN-3:0], p1, p0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/prbs31_pam4_symbol_checker.sv
// -----------------------------------------------------------------------------
// prbs31_pam4_symbol_checker
//
// Symbol-rate receive checker for a PRBS31 stream sent as Gray-coded PAM-4.
// Decodes each symbol, self-synchronises a local PRBS31 from the received
// data, then compares two bits per symbol and keeps saturating statistics.
// A windowed error count drops lock and re-seeds after an error burst.
//
// Ports
//   clk                  in   system clock
//   rst                  in   synchronous active-high reset
//   symbol_in            in   Gray-coded PAM-4 symbol
//   symbol_in_valid      in   symbol_in qualifier (at most one symbol per cycle)
//   clear_counters       in   zero the four statistics counters (lock untouched)
//   locked               out  high while the checker is locked
//   total_bits           out  bits compared while locked
//   total_bit_errors     out  mismatched bits while locked
//   total_symbol_errors  out  symbols with at least one mismatched bit
//   relock_count         out  number of locked -> seed transitions
// -----------------------------------------------------------------------------
module prbs31_pam4_symbol_checker
    import prbs31_pam4_symbol_checker_pkg::*;
#(
    parameter int COUNTER_WIDTH  = 32,
    parameter int SEED_SYMBOLS   = 16,
    parameter int LOCK_WINDOW    = 64,
    parameter int LOSS_THRESHOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               symbol_in,
    input  logic                     symbol_in_valid,
    input  logic                     clear_counters,
    output logic                     locked,
    output logic [COUNTER_WIDTH-1:0] total_bits,
    output logic [COUNTER_WIDTH-1:0] total_bit_errors,
    output logic [COUNTER_WIDTH-1:0] total_symbol_errors,
    output logic [COUNTER_WIDTH-1:0] relock_count
);

    localparam int SEED_W    = $clog2(SEED_SYMBOLS + 1);
    localparam int WIN_CNT_W = $clog2(LOCK_WINDOW + 1);
    localparam int WIN_ERR_W = $clog2(2 * LOCK_WINDOW + 1);
    localparam int NUM_CNT   = 4;

    localparam logic [SEED_W-1:0]        SEED_LAST  = SEED_W'(SEED_SYMBOLS - 1);
    localparam logic [WIN_CNT_W-1:0]     WIN_LAST   = WIN_CNT_W'(LOCK_WINDOW - 1);
    localparam logic [WIN_ERR_W-1:0]     LOSS_LIMIT = WIN_ERR_W'(LOSS_THRESHOLD);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX    = '1;

    // -------------------------------------------------------------------------
    // Symbol decode and comparison
    // -------------------------------------------------------------------------
    state_e               state_q;
    state_e               state_d;
    logic [SEED_W-1:0]    seed_cnt_q;
    logic [SEED_W-1:0]    seed_cnt_d;
    logic [WIN_CNT_W-1:0] win_cnt_q;
    logic [WIN_CNT_W-1:0] win_cnt_d;
    logic [WIN_ERR_W-1:0] win_err_q;
    logic [WIN_ERR_W-1:0] win_err_d;

    logic [1:0]           rx_bits;
    logic [1:0]           pred_bits;
    logic [1:0]           mismatch;
    logic [1:0]           sym_bit_errs;
    logic                 load_zero;
    logic                 seed_step;
    logic                 check_step;
    logic                 seed_last;
    logic                 win_last;
    logic [WIN_ERR_W-1:0] win_err_total;
    logic                 lose_lock;

    assign rx_bits      = gray_decode(symbol_in);
    assign mismatch     = rx_bits ^ pred_bits;
    assign sym_bit_errs = {1'b0, mismatch[1]} + {1'b0, mismatch[0]};

    assign seed_step  = symbol_in_valid && (state_q == ST_SEED);
    assign check_step = symbol_in_valid && (state_q == ST_LOCKED);
    assign seed_last  = seed_step && (seed_cnt_q == SEED_LAST);
    assign win_last   = check_step && (win_cnt_q == WIN_LAST);

    // Window total includes the symbol being checked right now.
    assign win_err_total = win_err_q + {{(WIN_ERR_W-2){1'b0}}, sym_bit_errs};
    assign lose_lock     = win_last && (win_err_total >= LOSS_LIMIT);

    prbs31_lfsr_2step u_lfsr (
        .clk          (clk),
        .rst          (rst),
        .load_en_i    (seed_step),
        .advance_en_i (check_step),
        .rx_bits_i    (rx_bits),
        .pred_bits_o  (pred_bits),
        .load_zero_o  (load_zero)
    );

    // -------------------------------------------------------------------------
    // Lock supervisor
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        seed_cnt_d = seed_cnt_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;

        unique case (state_q)
            ST_SEED: begin
                // Window is held clear so it starts fresh on entry to LOCKED.
                win_cnt_d = '0;
                win_err_d = '0;
                if (seed_step) begin
                    if (seed_last) begin
                        seed_cnt_d = '0;
                        // An all-zero register is the PRBS lock-up state and
                        // can never predict the stream: seed again instead.
                        if (!load_zero) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 1'b1;
                    end
                end
            end

            ST_LOCKED: begin
                if (check_step) begin
                    if (win_last) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (lose_lock) begin
                            state_d    = ST_SEED;
                            seed_cnt_d = '0;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_total;
                    end
                end
            end

            default: begin
                state_d = ST_SEED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SEED;
            seed_cnt_q <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            seed_cnt_q <= seed_cnt_d;
            win_cnt_q  <= win_cnt_d;
            win_err_q  <= win_err_d;
        end
    end

    assign locked = (state_q == ST_LOCKED);

    // -------------------------------------------------------------------------
    // Saturating statistics counters
    //   0: total_bits  1: total_bit_errors  2: total_symbol_errors  3: relock
    // -------------------------------------------------------------------------
    logic [1:0]               cnt_inc [NUM_CNT];
    logic [COUNTER_WIDTH-1:0] cnt_val [NUM_CNT];

    assign cnt_inc[0] = check_step ? 2'd2 : 2'd0;
    assign cnt_inc[1] = check_step ? sym_bit_errs : 2'd0;
    assign cnt_inc[2] = check_step ? {1'b0, |mismatch} : 2'd0;
    assign cnt_inc[3] = lose_lock ? 2'd1 : 2'd0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [COUNTER_WIDTH-1:0] cnt_q;
            logic [COUNTER_WIDTH-1:0] cnt_d;
            logic [COUNTER_WIDTH:0]   sum;

            // One extra bit catches the carry; any carry means the counter
            // would pass its maximum, so it pins there instead of wrapping.
            assign sum = {1'b0, cnt_q} + {{(COUNTER_WIDTH-1){1'b0}}, cnt_inc[gi]};

            always_comb begin
                cnt_d = sum[COUNTER_WIDTH-1:0];
                if (sum[COUNTER_WIDTH]) begin
                    cnt_d = CNT_MAX;
                end
            end

            // A clear overrides any increment landing in the same cycle.
            always_ff @(posedge clk) begin
                if (rst || clear_counters) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    assign total_bits          = cnt_val[0];
    assign total_bit_errors    = cnt_val[1];
    assign total_symbol_errors = cnt_val[2];
    assign relock_count        = cnt_val[3];

endmodule
